// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, memory owner encoding
// and the width of the optional statistics counters.
package dmem_arb_pkg;

  typedef enum logic {
    S_NORM,
    S_FORCE
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam int STAT_W = 16;

  function automatic logic cpu_active(input logic memwrite, input logic memread);
    return memwrite | memread;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Width-parameterised up-counter with synchronous clear that sticks at MAX.
// Used for the DMA starvation count and the optional statistics counters.
module arb_sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MIPS core and a DMA/debug
// port. Define DMEM_ARB_STATS_EN to add stall/grant statistics outputs.
//
// Handshake: dma_req is held until dma_gnt is seen high in the same cycle; the
// access happens at the rising edge ending that cycle. Read data returns on
// dma_rd with a one-cycle dma_rvalid pulse after that edge. cpu_stall high
// means the CPU access was not performed and the core must repeat it.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_adr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_dma_cnt
`endif
);

  localparam int             CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  arb_state_t    state;
  arb_state_t    state_next;
  owner_t        owner;
  logic          cpu_act;
  logic [CW-1:0] wait_cnt;
  logic          wait_clr;
  logic          wait_inc;
  logic          dma_read_hit;

  assign cpu_act = cpu_active(cpu_memwrite, cpu_memread);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_NORM;
    end else begin
      state <= state_next;
    end
  end

  // Ownership is forced to none while reset is low so nothing reaches dmem.
  always_comb begin
    state_next = S_NORM;
    owner      = OWN_NONE;
    cpu_stall  = 1'b0;
    if (reset) begin
      case (state)
        S_NORM: begin
          if (cpu_act) begin
            owner = OWN_CPU;
          end else if (dma_req) begin
            owner = OWN_DMA;
          end
          if (dma_req && cpu_act && (wait_cnt == WAIT_LAST)) begin
            state_next = S_FORCE;
          end
        end
        S_FORCE: begin
          owner      = OWN_DMA;
          cpu_stall  = cpu_act;
          state_next = S_NORM;
        end
        default: begin
          state_next = S_NORM;
        end
      endcase
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_a   = cpu_adr;
    mem_wd  = cpu_wd;
    dma_gnt = 1'b0;
    case (owner)
      OWN_CPU: begin
        mem_we = cpu_memwrite;
      end
      OWN_DMA: begin
        mem_we  = dma_we;
        mem_a   = dma_adr;
        mem_wd  = dma_wd;
        dma_gnt = 1'b1;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign cpu_rd = mem_rd;

  // Consecutive denials of a pending request; saturates at the force threshold.
  assign wait_clr = !dma_req || dma_gnt;
  assign wait_inc = dma_req && !dma_gnt;

  arb_sat_counter #(
    .W   (CW),
    .MAX (WAIT_LAST)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .cnt   (wait_cnt)
  );

  assign dma_read_hit = dma_gnt && !dma_we;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rd     <= '0;
    end else begin
      dma_rvalid <= dma_read_hit;
      if (dma_read_hit) begin
        dma_rd <= mem_rd;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  arb_sat_counter #(
    .W   (STAT_W),
    .MAX ({STAT_W{1'b1}})
  ) u_stat_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (cpu_stall),
    .cnt   (stat_stall_cnt)
  );

  arb_sat_counter #(
    .W   (STAT_W),
    .MAX ({STAT_W{1'b1}})
  ) u_stat_dma (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (dma_gnt),
    .cnt   (stat_dma_cnt)
  );
`endif

  // A stalled CPU store must never reach dmem.
  stall_we_a: assert property (@(posedge clk) disable iff (!reset)
    cpu_stall |-> (mem_we == dma_we));

  cnt_bound_a: assert property (@(posedge clk) disable iff (!reset)
    wait_cnt <= WAIT_LAST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word-addressed dmem.
// Stat outputs are connected and checked when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_adr;
  logic [31:0] dma_wd;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rd;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_dma_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram [0:63] = '{default: '0};

  // clock / reset
  always #5 clk = ~clk;

  assign mem_rd = ram[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_a[7:2]] <= mem_wd;
  end

  dmem_arbiter #(.MAX_WAIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_memwrite (cpu_memwrite),
    .cpu_memread  (cpu_memread),
    .cpu_adr      (cpu_adr),
    .cpu_wd       (cpu_wd),
    .cpu_rd       (cpu_rd),
    .cpu_stall    (cpu_stall),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_adr      (dma_adr),
    .dma_wd       (dma_wd),
    .dma_gnt      (dma_gnt),
    .dma_rvalid   (dma_rvalid),
    .dma_rd       (dma_rd),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_dma_cnt   (stat_dma_cnt)
`endif
  );

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held low with both requesters active
    reset        = 1'b0;
    cpu_memwrite = 1'b1;
    cpu_memread  = 1'b0;
    cpu_adr      = 32'h54;
    cpu_wd       = 32'h7;
    dma_req      = 1'b1;
    dma_we       = 1'b1;
    dma_adr      = 32'h08;
    dma_wd       = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    end
    check("rst_dma_rd", dma_rd, 32'd0);
    check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    check("rst_ram2", ram[2], 32'd0);

    // CPU store after release
    reset   = 1'b1;
    dma_req = 1'b0;
    settle();
    check("cpu_wr_mem_we", 32'(mem_we), 32'd1);
    check("cpu_wr_mem_a", mem_a, 32'h54);
    tick();
    check("cpu_wr_ram21", ram[21], 32'h7);
    cpu_memwrite = 1'b0;

    // back-to-back DMA write then read with CPU idle
    dma_req = 1'b1;
    dma_we  = 1'b1;
    dma_adr = 32'h10;
    dma_wd  = 32'hDEAD_BEEF;
    settle();
    check("dma_wr_gnt", 32'(dma_gnt), 32'd1);
    check("dma_wr_mem_a", mem_a, 32'h10);
    check("dma_wr_mem_we", 32'(mem_we), 32'd1);
    tick();
    check("dma_wr_ram4", ram[4], 32'hDEAD_BEEF);
    dma_we = 1'b0;
    settle();
    check("dma_rd_gnt", 32'(dma_gnt), 32'd1);
    check("dma_rd_mem_we", 32'(mem_we), 32'd0);
    check("dma_rd_no_rvalid_after_wr", 32'(dma_rvalid), 32'd0);
    tick();
    dma_req = 1'b0;
    settle();
    check("dma_rd_rvalid", 32'(dma_rvalid), 32'd1);
    check("dma_rd_data", dma_rd, 32'hDEAD_BEEF);
    tick();
    check("dma_rd_rvalid_pulse", 32'(dma_rvalid), 32'd0);
    check("dma_rd_hold", dma_rd, 32'hDEAD_BEEF);

    // preload word 8 via CPU
    cpu_memwrite = 1'b1;
    cpu_adr      = 32'h20;
    cpu_wd       = 32'hCAFE_0020;
    tick();
    cpu_memwrite = 1'b0;

    // starvation: CPU loads every cycle, DMA read of 0x20 pending
    cpu_memread = 1'b1;
    cpu_adr     = 32'h40;
    dma_req     = 1'b1;
    dma_we      = 1'b0;
    dma_adr     = 32'h20;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("starve_gnt", 32'(dma_gnt), 32'd0);
      check("starve_stall", 32'(cpu_stall), 32'd0);
      check("starve_wait_cnt", 32'(dut.wait_cnt), 32'(i));
      tick();
    end
    settle();
    check("force_gnt", 32'(dma_gnt), 32'd1);
    check("force_stall", 32'(cpu_stall), 32'd1);
    check("force_state", 32'(dut.state), 32'd1);
    check("force_mem_a", mem_a, 32'h20);
    check("force_mem_we", 32'(mem_we), 32'd0);
    check("force_wait_sat", 32'(dut.wait_cnt), 32'd7);
    tick();
    dma_req = 1'b0;
    settle();
    check("post_force_stall", 32'(cpu_stall), 32'd0);
    check("post_force_wait", 32'(dut.wait_cnt), 32'd0);
    check("post_force_state", 32'(dut.state), 32'd0);
    check("post_force_rvalid", 32'(dma_rvalid), 32'd1);
    check("post_force_rd", dma_rd, 32'hCAFE_0020);
    check("post_force_mem_a", mem_a, 32'h40);
    tick();

    // CPU idle on denied cycle 5
    dma_req = 1'b1;
    dma_adr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("idle5_gnt", 32'(dma_gnt), 32'd0);
      check("idle5_wait_cnt", 32'(dut.wait_cnt), 32'(i));
      tick();
    end
    cpu_memread = 1'b0;
    settle();
    check("idle5_grant", 32'(dma_gnt), 32'd1);
    check("idle5_stall", 32'(cpu_stall), 32'd0);
    tick();
    dma_req     = 1'b0;
    cpu_memread = 1'b1;
    settle();
    check("idle5_rvalid", 32'(dma_rvalid), 32'd1);
    check("idle5_rd", dma_rd, 32'hDEAD_BEEF);
    check("idle5_wait_clr", 32'(dut.wait_cnt), 32'd0);
    tick();

    // CPU idle exactly in the cycle the counter would saturate
    dma_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      check("sat_idle_gnt", 32'(dma_gnt), 32'd0);
      tick();
    end
    cpu_memread = 1'b0;
    settle();
    check("sat_idle_wait", 32'(dut.wait_cnt), 32'd7);
    check("sat_idle_grant", 32'(dma_gnt), 32'd1);
    tick();
    dma_req     = 1'b0;
    cpu_memread = 1'b1;
    settle();
    check("sat_idle_no_force", 32'(dut.state), 32'd0);
    check("sat_idle_wait_clr", 32'(dut.wait_cnt), 32'd0);
    check("sat_idle_stall", 32'(cpu_stall), 32'd0);
    tick();

    // dma_req withdrawn while waiting
    dma_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    settle();
    check("drop_wait_before", 32'(dut.wait_cnt), 32'd3);
    dma_req = 1'b0;
    tick();
    check("drop_wait_clr", 32'(dut.wait_cnt), 32'd0);
    check("drop_state", 32'(dut.state), 32'd0);
    cpu_memread = 1'b0;

    // forced DMA write colliding with a CPU store to 0x30
    cpu_memwrite = 1'b1;
    cpu_adr      = 32'h34;
    cpu_wd       = 32'h9;
    dma_req      = 1'b1;
    dma_we       = 1'b1;
    dma_adr      = 32'h30;
    dma_wd       = 32'h2;
    for (int i = 0; i < 8; i++) tick();
    cpu_adr = 32'h30;
    cpu_wd  = 32'h1;
    settle();
    check("coll_stall", 32'(cpu_stall), 32'd1);
    check("coll_mem_we", 32'(mem_we), 32'd1);
    check("coll_mem_wd", mem_wd, 32'h2);
    check("coll_mem_a", mem_a, 32'h30);
    tick();
    check("coll_ram12_dma", ram[12], 32'h2);
    dma_req = 1'b0;
    settle();
    check("replay_stall", 32'(cpu_stall), 32'd0);
    check("replay_mem_wd", mem_wd, 32'h1);
    tick();
    check("replay_ram12_cpu", ram[12], 32'h1);
    check("replay_ram13", ram[13], 32'h9);
    cpu_memwrite = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    check("stat_stall_run", 32'(stat_stall_cnt), 32'd2);
    check("stat_dma_run", 32'(stat_dma_cnt), 32'd6);
`endif

    // reset lands on a would-be granted DMA read
    dma_req = 1'b1;
    dma_we  = 1'b0;
    dma_adr = 32'h10;
    reset   = 1'b0;
    settle();
    check("rst_rd_gnt", 32'(dma_gnt), 32'd0);
    check("rst_rd_mem_we", 32'(mem_we), 32'd0);
    tick();
    check("rst_rd_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_rd_data", dma_rd, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    check("stat_stall_rst", 32'(stat_stall_cnt), 32'd0);
    check("stat_dma_rst", 32'(stat_dma_cnt), 32'd0);
`endif
    reset   = 1'b1;
    dma_req = 1'b0;
    tick();
    check("rst_rd_rvalid_after", 32'(dma_rvalid), 32'd0);
    check("rst_rd_wait", 32'(dut.wait_cnt), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
